// File: rtl/grf_write_arbiter.sv
// GRF write-port arbiter: pipeline W stage (A) over multi-cycle unit (B),
// with a one-cycle pipeline freeze to drain B. Option: GRF_WRITE_TRACE_EN.
module grf_write_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aValid,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [DATA_W-1:0] aData,
    input  logic              bValid,
    output logic              bReady,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [DATA_W-1:0] bData,
    output logic              stallReq,
    output logic              writable,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] writeData,
    output logic              protoErr
`ifdef GRF_WRITE_TRACE_EN
    ,
    input  logic [DATA_W-1:0] aPC,
    input  logic [DATA_W-1:0] bPC
`endif
);

    typedef enum logic {
        NORMAL,
        DRAIN
    } state_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        grant_a;
    logic        grant_b;
    logic        b_blocked;
    logic        hit_limit;

    assign stallReq = (state == DRAIN);

    // B is accepted whenever A is idle, and always while the pipeline is frozen
    always_comb begin
        bReady = 1'b0;
        if (!reset) begin
            bReady = (state == DRAIN) || !aValid;
        end
    end

    // Per-cycle grant decision and starvation detection
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        b_blocked = 1'b0;
        hit_limit = 1'b0;
        if (state == NORMAL) begin
            grant_a   = aValid;
            grant_b   = !aValid && bValid;
            b_blocked = bValid && aValid;
            hit_limit = b_blocked && ((wait_cnt + 8'd1) >= WAIT_LIM);
        end else begin
            grant_b = bValid;
        end
    end

    // State, wait counter, registered write port and sticky protocol flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= NORMAL;
            wait_cnt  <= '0;
            writable  <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
            protoErr  <= 1'b0;
        end else begin
            if (grant_a) begin
                writable  <= (aAddr != '0);
                writeAddr <= aAddr;
                writeData <= aData;
            end else if (grant_b) begin
                writable  <= (bAddr != '0);
                writeAddr <= bAddr;
                writeData <= bData;
            end else begin
                writable <= 1'b0;
            end

            if (state == DRAIN && aValid) begin
                protoErr <= 1'b1;
            end

            if (state == DRAIN) begin
                state    <= NORMAL;
                wait_cnt <= '0;
            end else if (hit_limit) begin
                state    <= DRAIN;
                wait_cnt <= WAIT_LIM;
            end else if (b_blocked) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

`ifdef GRF_WRITE_TRACE_EN
    // Log each committed register write with the PC of the granted port
    always @(posedge clk) begin
        if (!reset) begin
            if (grant_a && aAddr != '0)
                $display("%d@%h: $%d <= %h", $time, aPC, aAddr, aData);
            else if (grant_b && bAddr != '0)
                $display("%d@%h: $%d <= %h", $time, bPC, bAddr, bData);
        end
    end
`endif

endmodule
